// File: rtl/ecc_io_sequencer.sv
// ecc_io_sequencer: assembles x/y/k/b operands for a GF(2^M) point-multiplication
// core from a W-bit input stream, and streams the core's dx/dy result back out.
module ecc_io_sequencer #(
    parameter int unsigned M = 163,
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         core_start,
    output logic [M-1:0] core_x,
    output logic [M-1:0] core_y,
    output logic [M-1:0] core_k,
    output logic [M-1:0] core_b,
    input  logic         core_done,
    input  logic [M-1:0] core_dx,
    input  logic [M-1:0] core_dy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         k_zero
);
    localparam int unsigned B  = (M + W - 1) / W;
    localparam int unsigned BW = (B > 1) ? $clog2(B) : 1;
    localparam int unsigned OW = $clog2(2 * B);

    typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_t;
    state_t state, state_nx;

    logic [BW-1:0] beat;
    logic [1:0]    op;
    logic [OW-1:0] ocnt;
    logic [M-1:0]  x_q, y_q, k_q, b_q, dx_q, dy_q;
    logic          kz_q;
    logic          last_beat, last_word;
    logic [OW-1:0] wsel;
    logic [M-1:0]  res;
    logic [W-1:0]  out_word;

    // Widening to B*W lets the bits of the final beat above M fall off on truncation.
    function automatic logic [M-1:0] put_word(input logic [M-1:0] cur,
                                              input logic [W-1:0] d,
                                              input logic [BW-1:0] idx);
        logic [B*W-1:0] msk;
        logic [B*W-1:0] val;
        msk = (B*W)'({W{1'b1}}) << (32'(idx) * W);
        val = (B*W)'(d) << (32'(idx) * W);
        return M'(((B*W)'(cur) & ~msk) | val);
    endfunction

    assign last_beat = (beat == BW'(B - 1));
    assign last_word = (ocnt == OW'(2 * B - 1));

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = 1'b1;
        case (state)
            LOAD: begin
                in_ready = ~rst;
                busy     = 1'b0;
                if (in_valid && op == 2'd3 && last_beat) state_nx = START;
            end
            START: begin
                core_start = (k_q != '0);
                state_nx   = (k_q != '0) ? WAIT : UNLOAD;
            end
            WAIT: begin
                if (core_done) state_nx = UNLOAD;
            end
            UNLOAD: begin
                out_valid = 1'b1;
                out_last  = last_word;
                if (out_ready && last_word) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    always_comb begin
        wsel     = (ocnt < OW'(B)) ? ocnt : ocnt - OW'(B);
        res      = (ocnt < OW'(B)) ? dx_q : dy_q;
        out_word = W'(res >> (32'(wsel) * W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            beat  <= '0;
            op    <= '0;
            ocnt  <= '0;
            x_q   <= '0;
            y_q   <= '0;
            k_q   <= '0;
            b_q   <= '0;
            dx_q  <= '0;
            dy_q  <= '0;
            kz_q  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        case (op)
                            2'd0:    x_q <= put_word(x_q, in_data, beat);
                            2'd1:    y_q <= put_word(y_q, in_data, beat);
                            2'd2:    k_q <= put_word(k_q, in_data, beat);
                            default: b_q <= put_word(b_q, in_data, beat);
                        endcase
                        beat <= last_beat ? '0 : beat + 1'b1;
                        if (last_beat) op <= op + 2'd1;
                    end
                end
                START: begin
                    kz_q <= (k_q == '0);
                    if (k_q == '0) begin
                        dx_q <= '0;
                        dy_q <= '0;
                    end
                end
                WAIT: begin
                    if (core_done) begin
                        dx_q <= core_dx;
                        dy_q <= core_dy;
                    end
                end
                UNLOAD: begin
                    if (out_ready) ocnt <= last_word ? '0 : ocnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign core_x   = x_q;
    assign core_y   = y_q;
    assign core_k   = k_q;
    assign core_b   = b_q;
    assign k_zero   = kz_q;
    assign out_data = (state == UNLOAD) ? out_word : '0;
endmodule

// File: tb/tb_ecc_io_sequencer.sv
// Bench for ecc_io_sequencer: three parameterisations share one stimulus path,
// checked against an arithmetic model of operand assembly and result slicing.
module tb_ecc_io_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    int           sel = 0;
    logic         drv_valid = 1'b0, drv_done = 1'b0, drv_ready = 1'b0;
    logic [31:0]  drv_data = '0;
    logic [162:0] drv_dx = '0, drv_dy = '0;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;

    int M_OF [3] = '{163, 8, 17};
    int W_OF [3] = '{32, 8, 4};
    logic [31:0] words [4][6];

    logic         in_ready0, core_start0, out_valid0, out_last0, busy0, k_zero0;
    logic [162:0] cx0, cy0, ck0, cb0;
    logic [31:0]  od0;
    logic         in_ready1, core_start1, out_valid1, out_last1, busy1, k_zero1;
    logic [7:0]   cx1, cy1, ck1, cb1;
    logic [7:0]   od1;
    logic         in_ready2, core_start2, out_valid2, out_last2, busy2, k_zero2;
    logic [16:0]  cx2, cy2, ck2, cb2;
    logic [3:0]   od2;

    ecc_io_sequencer #(.M(163), .W(32)) dut0 (
        .clk(clk), .rst(rst), .in_valid(drv_valid && sel == 0), .in_ready(in_ready0),
        .in_data(drv_data), .core_start(core_start0), .core_x(cx0), .core_y(cy0),
        .core_k(ck0), .core_b(cb0), .core_done(drv_done && sel == 0), .core_dx(drv_dx),
        .core_dy(drv_dy), .out_valid(out_valid0), .out_ready(drv_ready && sel == 0),
        .out_data(od0), .out_last(out_last0), .busy(busy0), .k_zero(k_zero0));

    ecc_io_sequencer #(.M(8), .W(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(drv_valid && sel == 1), .in_ready(in_ready1),
        .in_data(drv_data[7:0]), .core_start(core_start1), .core_x(cx1), .core_y(cy1),
        .core_k(ck1), .core_b(cb1), .core_done(drv_done && sel == 1), .core_dx(drv_dx[7:0]),
        .core_dy(drv_dy[7:0]), .out_valid(out_valid1), .out_ready(drv_ready && sel == 1),
        .out_data(od1), .out_last(out_last1), .busy(busy1), .k_zero(k_zero1));

    ecc_io_sequencer #(.M(17), .W(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(drv_valid && sel == 2), .in_ready(in_ready2),
        .in_data(drv_data[3:0]), .core_start(core_start2), .core_x(cx2), .core_y(cy2),
        .core_k(ck2), .core_b(cb2), .core_done(drv_done && sel == 2), .core_dx(drv_dx[16:0]),
        .core_dy(drv_dy[16:0]), .out_valid(out_valid2), .out_ready(drv_ready && sel == 2),
        .out_data(od2), .out_last(out_last2), .busy(busy2), .k_zero(k_zero2));

    logic         o_in_ready, o_core_start, o_out_valid, o_out_last, o_busy, o_k_zero;
    logic [162:0] o_cx, o_cy, o_ck, o_cb;
    logic [31:0]  o_od;

    always_comb begin
        o_in_ready = in_ready0; o_core_start = core_start0; o_out_valid = out_valid0;
        o_out_last = out_last0; o_busy = busy0; o_k_zero = k_zero0;
        o_cx = cx0; o_cy = cy0; o_ck = ck0; o_cb = cb0; o_od = od0;
        case (sel)
            1: begin
                o_in_ready = in_ready1; o_core_start = core_start1; o_out_valid = out_valid1;
                o_out_last = out_last1; o_busy = busy1; o_k_zero = k_zero1;
                o_cx = 163'(cx1); o_cy = 163'(cy1); o_ck = 163'(ck1); o_cb = 163'(cb1);
                o_od = 32'(od1);
            end
            2: begin
                o_in_ready = in_ready2; o_core_start = core_start2; o_out_valid = out_valid2;
                o_out_last = out_last2; o_busy = busy2; o_k_zero = k_zero2;
                o_cx = 163'(cx2); o_cy = 163'(cy2); o_ck = 163'(ck2); o_cb = 163'(cb2);
                o_od = 32'(od2);
            end
            default: ;
        endcase
    end

    always @(negedge clk) if (o_core_start === 1'b1) start_cnt++;

    function automatic logic [31:0] wmask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Operand value = sum of word[j] * 2^(j*w), reduced modulo 2^m.
    function automatic logic [255:0] assemble(input int op, input int m, input int w, input int b);
        logic [255:0] acc = '0;
        for (int j = 0; j < b; j++) acc = acc + (256'(words[op][j] & wmask(w)) << (j * w));
        return acc % (256'd1 << m);
    endfunction

    function automatic logic [31:0] slice(input logic [255:0] v, input int j, input int w);
        return 32'(v >> (j * w)) & wmask(w);
    endfunction

    function automatic logic [162:0] rnd163();
        logic [191:0] t;
        for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom;
        return t[162:0];
    endfunction

    task automatic run_frame(input int s, input bit kz, input bit rin, input bit stall,
                             input bit rout, input int dly, input bit stray, input bit nominal,
                             input bit abort, input logic [162:0] dx, input logic [162:0] dy);
        int m, w, b, idx, cyc, sc0, stalled;
        bit v, r;
        logic [255:0] expv [4];
        logic [255:0] rdx, rdy;
        logic [31:0] exp_out [12];
        sel = s; m = M_OF[s]; w = W_OF[s]; b = (m + w - 1) / w;
        for (int o = 0; o < 4; o++)
            for (int j = 0; j < 6; j++) words[o][j] = $urandom & wmask(w);
        if (nominal) words[0][5] = 32'hFFFF_FFFF;
        if (kz) for (int j = 0; j < 6; j++) words[2][j] = '0;
        else if (assemble(2, m, w, b) == '0) words[2][0] = 32'd1;
        for (int o = 0; o < 4; o++) expv[o] = assemble(o, m, w, b);
        rdx = kz ? '0 : (256'(dx) % (256'd1 << m));
        rdy = kz ? '0 : (256'(dy) % (256'd1 << m));
        for (int j = 0; j < b; j++) begin
            exp_out[j] = slice(rdx, j, w);
            exp_out[b + j] = slice(rdy, j, w);
        end
        sc0 = start_cnt;

        idx = 0; cyc = 0;
        while (idx < 4 * b && cyc < 2000) begin
            @(negedge clk); cyc++;
            total++;
            if (o_busy !== 1'b0 || o_in_ready !== 1'b1) begin
                bad++; $display("FAIL load_ctrl busy=%b in_ready=%b exp busy=0 in_ready=1", o_busy, o_in_ready);
            end
            v = rin ? ($urandom_range(0, 2) != 0) : 1'b1;
            drv_valid = v;
            drv_data = words[idx / b][idx % b] | ($urandom & ~wmask(w));
            drv_done = stray && ($urandom_range(0, 3) == 0);
            drv_dx = rnd163(); drv_dy = rnd163();
            if (v && o_in_ready) idx++;
        end
        if (idx < 4 * b) begin
            total++; bad++;
            $display("FAIL load_timeout accepted=%0d exp=%0d", idx, 4 * b);
        end
        @(negedge clk);
        drv_valid = 1'b0; drv_done = 1'b0;
        total++;
        if (o_core_start !== !kz) begin
            bad++; $display("FAIL start_pulse got=%b exp=%b", o_core_start, !kz);
        end
        total++;
        if (o_cx !== 163'(expv[0])) begin bad++; $display("FAIL core_x got=%h exp=%h", o_cx, 163'(expv[0])); end
        total++;
        if (o_cy !== 163'(expv[1])) begin bad++; $display("FAIL core_y got=%h exp=%h", o_cy, 163'(expv[1])); end
        total++;
        if (o_ck !== 163'(expv[2])) begin bad++; $display("FAIL core_k got=%h exp=%h", o_ck, 163'(expv[2])); end
        total++;
        if (o_cb !== 163'(expv[3])) begin bad++; $display("FAIL core_b got=%h exp=%h", o_cb, 163'(expv[3])); end
        if (nominal) begin
            total++;
            if (o_cx[162:160] !== 3'b111) begin bad++; $display("FAIL x_top got=%b exp=111", o_cx[162:160]); end
        end

        if (abort) begin
            repeat (dly) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0; drv_done = 1'b1; drv_dx = dx; drv_dy = dy;
            @(negedge clk);
            drv_done = 1'b0;
            repeat (5) begin
                total++;
                if (o_out_valid !== 1'b0 || o_busy !== 1'b0 || o_in_ready !== 1'b1) begin
                    bad++; $display("FAIL abort_idle out_valid=%b busy=%b in_ready=%b exp 0 0 1", o_out_valid, o_busy, o_in_ready);
                end
                @(negedge clk);
            end
            total++;
            if (o_cx !== '0 || start_cnt !== sc0 + 1) begin
                bad++; $display("FAIL abort_clear core_x=%h starts=%0d exp 0 %0d", o_cx, start_cnt - sc0, 1);
            end
            return;
        end

        if (!kz) begin
            repeat (dly) begin
                @(negedge clk);
                total++;
                if (o_out_valid !== 1'b0 || o_busy !== 1'b1) begin
                    bad++; $display("FAIL wait_state out_valid=%b busy=%b exp 0 1", o_out_valid, o_busy);
                end
            end
            drv_done = 1'b1; drv_dx = dx; drv_dy = dy;
            @(negedge clk);
            drv_done = 1'b0; drv_dx = rnd163(); drv_dy = rnd163();
        end else begin
            @(negedge clk);
        end
        total++;
        if (o_out_valid !== 1'b1) begin bad++; $display("FAIL out_valid_rise got=%b exp=1", o_out_valid); end
        total++;
        if (o_k_zero !== kz) begin bad++; $display("FAIL k_zero got=%b exp=%b", o_k_zero, kz); end

        idx = 0; cyc = 0; stalled = 0;
        while (idx < 2 * b && cyc < 2000) begin
            total++;
            if (o_out_valid !== 1'b1 || o_od !== exp_out[idx] || o_out_last !== (idx == 2 * b - 1)) begin
                bad++;
                $display("FAIL out_word[%0d] valid=%b data=%h last=%b exp 1 %h %b", idx, o_out_valid,
                         o_od, o_out_last, exp_out[idx], idx == 2 * b - 1);
            end
            r = 1'b1;
            if (stall && idx == 2 && stalled < 5) begin r = 1'b0; stalled++; end
            else if (rout) r = 1'($urandom_range(0, 1));
            drv_ready = r;
            if (r) idx++;
            @(negedge clk); cyc++;
        end
        drv_ready = 1'b0;
        if (idx < 2 * b) begin
            total++; bad++;
            $display("FAIL unload_timeout words=%0d exp=%0d", idx, 2 * b);
        end
        total++;
        if (o_out_valid !== 1'b0 || o_busy !== 1'b0 || o_in_ready !== 1'b1) begin
            bad++; $display("FAIL frame_end out_valid=%b busy=%b in_ready=%b exp 0 0 1", o_out_valid, o_busy, o_in_ready);
        end
        total++;
        if (start_cnt !== sc0 + (kz ? 0 : 1)) begin
            bad++; $display("FAIL start_count got=%0d exp=%0d", start_cnt - sc0, kz ? 0 : 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                sel = s; #1;
                total++;
                if (o_in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready[%0d] got=%b exp=0", s, o_in_ready); end
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            total++;
            if (o_in_ready !== 1'b1 || o_core_start !== 1'b0 || o_out_valid !== 1'b0 || o_out_last !== 1'b0 ||
                o_busy !== 1'b0 || o_k_zero !== 1'b0 || o_od !== '0 ||
                (o_cx | o_cy | o_ck | o_cb) !== '0) begin
                bad++;
                $display("FAIL reset_outputs[%0d] rdy=%b st=%b ov=%b ol=%b busy=%b kz=%b od=%h ops_or=%h exp 1 0 0 0 0 0 0 0",
                         s, o_in_ready, o_core_start, o_out_valid, o_out_last, o_busy, o_k_zero, o_od,
                         o_cx | o_cy | o_ck | o_cb);
            end
        end
        sel = 0;
    endtask

    task automatic test_nominal();
        run_frame(0, 0, 0, 0, 0, 100, 0, 1, 0, 163'd1, 163'd2);
    endtask

    task automatic test_backpressure();
        run_frame(0, 0, 1, 1, 0, 7, 0, 0, 0, rnd163(), rnd163());
        run_frame(0, 0, 1, 0, 1, 3, 0, 0, 0, rnd163(), rnd163());
    endtask

    task automatic test_k_zero();
        run_frame(0, 1, 0, 0, 0, 1, 0, 0, 0, rnd163(), rnd163());
        run_frame(2, 1, 1, 0, 1, 1, 0, 0, 0, rnd163(), rnd163());
    endtask

    task automatic test_stray_done();
        run_frame(0, 0, 1, 0, 0, 4, 1, 0, 0, rnd163(), rnd163());
        run_frame(0, 0, 0, 0, 0, 2, 0, 0, 0, rnd163(), rnd163());
    endtask

    task automatic test_abort();
        run_frame(0, 0, 0, 0, 0, 10, 0, 0, 1, rnd163(), rnd163());
        run_frame(0, 0, 0, 0, 1, 5, 0, 0, 0, rnd163(), rnd163());
    endtask

    task automatic test_parametric();
        run_frame(1, 0, 0, 0, 0, 3, 0, 0, 0, rnd163(), rnd163());
        run_frame(1, 0, 1, 1, 1, 2, 1, 0, 0, rnd163(), rnd163());
        run_frame(2, 0, 0, 1, 0, 4, 0, 0, 0, rnd163(), rnd163());
        run_frame(2, 0, 1, 0, 1, 6, 1, 0, 0, rnd163(), rnd163());
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_k_zero();
        test_stray_done();
        test_abort();
        test_parametric();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
